// File: rtl/tm_lif_pkg.sv
// tm_lif_pkg: shared widths and per-neuron state record for the LIF array.
// Provides ACC_W/IDX_W derivations and lif_state_t {v, acc, refc}.
package tm_lif_pkg;

  localparam int DEF_V_W   = 10;
  localparam int DEF_SYN_W = 10;
  localparam int DEF_REF_W = 4;

  function automatic int acc_w(input int syn_w);
    return syn_w + 2;
  endfunction

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic [DEF_V_W-1:0]     v;
    logic [DEF_SYN_W+1:0]   acc;
    logic [DEF_REF_W-1:0]   refc;
  } lif_state_t;

endpackage

// File: rtl/tm_lif_array_slot_update.sv
// lif_slot_update: combinational charge/leak/threshold/refractory step.
// In: one neuron's v/acc/ref, tick flags, config. Out: next v/acc/ref, spike.
module lif_slot_update #(
  parameter int V_W   = 10,
  parameter int ACC_W = 12,
  parameter int REF_W = 4
) (
  input  logic [V_W-1:0]   v_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [REF_W-1:0] ref_i,
  input  logic             charge_tick_i,
  input  logic             leak_tick_i,
  input  logic [V_W-1:0]   vth_i,
  input  logic [V_W-1:0]   vrst_i,
  input  logic [REF_W-1:0] refrac_i,
  output logic [V_W-1:0]   v_o,
  output logic [ACC_W-1:0] acc_o,
  output logic [REF_W-1:0] ref_o,
  output logic             spike_o
);

  localparam int S_W = ((V_W > ACC_W) ? V_W : ACC_W) + 1;
  localparam logic [V_W-1:0] VMAX = '1;

  logic [S_W-1:0] sum;
  logic [V_W-1:0] vc;
  logic [V_W-1:0] vn;

  always_comb begin
    sum = S_W'(v_i) + (charge_tick_i ? S_W'(acc_i) : S_W'(0));
    vc  = (sum > S_W'(VMAX)) ? VMAX : sum[V_W-1:0];
    vn  = (leak_tick_i && vc != '0) ? vc - 1'b1 : vc;
  end

  always_comb begin
    v_o     = vn;
    acc_o   = charge_tick_i ? '0 : acc_i;
    ref_o   = '0;
    spike_o = 1'b0;
    unique case (1'b1)
      (ref_i != '0): begin
        v_o   = vrst_i;
        acc_o = '0;
        ref_o = ref_i - 1'b1;
      end
      (vn >= vth_i): begin
        v_o     = vrst_i;
        ref_o   = refrac_i;
        spike_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tm_lif_array.sv
// tm_lif_array: N_NEURON LIF neurons sharing one slot datapath, one slot/cycle.
// In: clk_in, reset, syn_* events, rates, Vrst/Vth/refrac. Out: spike_*, sweep_done.
module tm_lif_array
  import tm_lif_pkg::*;
#(
  parameter int N_NEURON = 16,
  parameter int V_W      = 10,
  parameter int SYN_W    = 10,
  parameter int RATE_W   = 9,
  parameter int REF_W    = 4,
  localparam int IDX_W   = idx_w(N_NEURON),
  localparam int ACC_W   = acc_w(SYN_W)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              syn_valid,
  input  logic [IDX_W-1:0]  syn_idx,
  input  logic [SYN_W-1:0]  syn_i,
  input  logic [RATE_W-1:0] leak_rate,
  input  logic [RATE_W-1:0] charge_rate,
  input  logic [V_W-1:0]    Vrst,
  input  logic [V_W-1:0]    Vth,
  input  logic [REF_W-1:0]  refrac_sweeps,
  output logic              spike_valid,
  output logic [IDX_W-1:0]  spike_idx,
  output logic              sweep_done
);

  logic [V_W-1:0]    v_q   [N_NEURON];
  logic [ACC_W-1:0]  acc_q [N_NEURON];
  logic [REF_W-1:0]  ref_q [N_NEURON];

  logic [IDX_W-1:0]  idx_q;
  logic [RATE_W-1:0] lcnt_q, ccnt_q;
  logic [RATE_W-1:0] lcnt_d, ccnt_d;
  logic              lt_q, ct_q;
  logic [V_W-1:0]    vth_q, vrst_q;
  logic [REF_W-1:0]  refr_q;

  logic              spike_valid_q, sweep_done_q;
  logic [IDX_W-1:0]  spike_idx_q;

  logic              sweep_start;
  logic              leak_tick, charge_tick;
  logic [V_W-1:0]    vth_e, vrst_e;
  logic [REF_W-1:0]  refr_e;

  logic [V_W-1:0]    upd_v;
  logic [ACC_W-1:0]  upd_acc;
  logic [REF_W-1:0]  upd_ref;
  logic              upd_spike;

  logic              syn_drop;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]  acc_syn;

  // Slot 0 uses the live config/ticks; later slots see the copy taken there.
  assign sweep_start = (idx_q == '0);
  assign leak_tick   = sweep_start ? (lcnt_q == leak_rate)   : lt_q;
  assign charge_tick = sweep_start ? (ccnt_q == charge_rate) : ct_q;
  assign vth_e       = sweep_start ? Vth           : vth_q;
  assign vrst_e      = sweep_start ? Vrst          : vrst_q;
  assign refr_e      = sweep_start ? refrac_sweeps : refr_q;
  assign lcnt_d      = leak_tick   ? '0 : lcnt_q + 1'b1;
  assign ccnt_d      = charge_tick ? '0 : ccnt_q + 1'b1;

  lif_slot_update #(
    .V_W   (V_W),
    .ACC_W (ACC_W),
    .REF_W (REF_W)
  ) u_slot (
    .v_i           (v_q[idx_q]),
    .acc_i         (acc_q[idx_q]),
    .ref_i         (ref_q[idx_q]),
    .charge_tick_i (charge_tick),
    .leak_tick_i   (leak_tick),
    .vth_i         (vth_e),
    .vrst_i        (vrst_e),
    .refrac_i      (refr_e),
    .v_o           (upd_v),
    .acc_o         (upd_acc),
    .ref_o         (upd_ref),
    .spike_o       (upd_spike)
  );

  // An event hitting the slot being updated stacks on the post-update acc,
  // so a charge-cycle collision leaves exactly syn_i pending.
  assign syn_drop = (ref_q[syn_idx] != '0);
  assign acc_base = (syn_idx == idx_q) ? upd_acc : acc_q[syn_idx];
  assign acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(syn_i);
  assign acc_syn  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURON; i++) begin
        v_q[i]   <= '0;
        acc_q[i] <= '0;
        ref_q[i] <= '0;
      end
      idx_q         <= '0;
      lcnt_q        <= '0;
      ccnt_q        <= '0;
      lt_q          <= 1'b0;
      ct_q          <= 1'b0;
      vth_q         <= '0;
      vrst_q        <= '0;
      refr_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      sweep_done_q  <= 1'b0;
    end else begin
      idx_q <= idx_q + 1'b1;
      if (sweep_start) begin
        lcnt_q <= lcnt_d;
        ccnt_q <= ccnt_d;
        lt_q   <= leak_tick;
        ct_q   <= charge_tick;
        vth_q  <= Vth;
        vrst_q <= Vrst;
        refr_q <= refrac_sweeps;
      end
      v_q[idx_q]   <= upd_v;
      acc_q[idx_q] <= upd_acc;
      ref_q[idx_q] <= upd_ref;
      if (syn_valid && !syn_drop) begin
        acc_q[syn_idx] <= acc_syn;
      end
      spike_valid_q <= upd_spike;
      if (upd_spike) begin
        spike_idx_q <= idx_q;
      end
      sweep_done_q <= (idx_q == IDX_W'(N_NEURON - 1));
    end
  end

  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign sweep_done  = sweep_done_q;

endmodule

// File: doc/tm_lif_array.md
# tm_lif_array

Time-multiplexed array of `N_NEURON` leaky integrate-and-fire neurons sharing one update datapath. Each clock the scheduler visits one neuron slot and applies charge, leak, threshold and refractory rules. Synaptic events arrive as indexed pulses. Spikes leave as indexed pulses to the downstream router. This block succeeds the single-neuron TM LIF with configurable width, neuron count and a refractory mode.

## Interface
- `N_NEURON`, 16: neurons in the array; power of two, ≥2.
- `V_W`, 10: membrane potential width, unsigned.
- `SYN_W`, 10: synaptic weight width, unsigned.
- `RATE_W`, 9: leak/charge prescaler width.
- `REF_W`, 4: refractory counter width.
- `clk_in` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `syn_valid` in 1: synaptic event strobe.
- `syn_idx` in clog2(N_NEURON): target neuron.
- `syn_i` in SYN_W: weight to add.
- `leak_rate` in RATE_W: sweeps between leak ticks, minus one.
- `charge_rate` in RATE_W: sweeps between charge ticks, minus one.
- `Vrst` in V_W: post-spike reset potential.
- `Vth` in V_W: firing threshold.
- `refrac_sweeps` in REF_W: refractory length in sweeps; 0 disables refractory.
- `spike_valid` out 1: one-cycle spike pulse.
- `spike_idx` out clog2(N_NEURON): index of the spiking neuron.
- `sweep_done` out 1: pulses after slot N_NEURON-1 is processed.

## Operation
- State per neuron: `V` (V_W bits), `acc` (ACC_W = SYN_W+2 bits), and `ref` (REF_W bits).
- Slot pointer `idx` increments every cycle and wraps from N_NEURON-1 to 0. One full pass is a sweep.
- At `idx==0`, the block samples `leak_rate`, `charge_rate`, `Vrst`, `Vth` and `refrac_sweeps` into shadow registers. Changes made mid-sweep take effect on the next sweep.
- Prescalers `lcnt` and `ccnt` are evaluated at `idx==0`:
  - If `lcnt==leak_rate`, `leak_tick` is high for the whole sweep and `lcnt` clears to 0.
  - Otherwise `lcnt` increments.
  - `charge_tick` and `ccnt` follow the same rule against `charge_rate`.
  - A rate of 0 produces a tick on every sweep.
- Synaptic input: when `syn_valid` is high, `acc[syn_idx]` gains `syn_i`, saturating at 2^ACC_W−1. If `ref[syn_idx]!=0`, the event is dropped.
- Slot update for neuron `k = idx`, when `ref[k]==0`:
  - `Vc = V + (charge_tick ? acc : 0)`, saturating at 2^V_W−1.
  - `Vn = Vc − (leak_tick ? 1 : 0)`, clamped at 0.
  - If `Vn >= Vth`, the neuron spikes: `V <= Vrst`, `ref <= refrac_sweeps`, `spike_valid` and `spike_idx` are set.
  - Otherwise `V <= Vn`.
  - `acc` clears when `charge_tick` is high.
- Slot update when `ref[k]!=0`: `V <= Vrst`, `acc <= 0`, and `ref` decrements. No spike is possible.
- Simultaneous event: if `syn_valid` targets `k` in the same cycle that `k` clears its `acc`, then `acc[k] <= syn_i`. The new event is kept and applies at the next charge.
- If `Vrst >= Vth`, the neuron spikes on every eligible slot. This is legal behaviour.

## Timing
- Reset values: all `V`, `acc`, `ref`, `idx`, `lcnt` and `ccnt` are 0; shadow registers are 0; `spike_valid=0`, `spike_idx=0`, `sweep_done=0`.
- In the first cycle after `reset` falls, `idx=0` and config is sampled.
- Slot update is a single-cycle read-modify-write.
- `spike_valid`, `spike_idx` and `sweep_done` are registered. They appear one cycle after the slot cycle and last exactly one cycle.
- A sweep takes N_NEURON cycles. A given neuron spikes at most once per sweep.
- Asserting `reset` mid-sweep immediately clears all state, including pending `acc`, and drops any in-flight spike pulse.

## Structure
- Package `tm_lif_pkg`: `ACC_W` and `IDX_W` derivation functions, plus a `lif_state_t` struct of {V, acc, ref}.
- Sub-module `lif_slot_update`: combinational charge/leak/threshold/refractory datapath for one neuron, instantiated once.
- Top level contains: state arrays, slot pointer, prescalers, shadow config and output registers.

## Test plan
All scenarios use default parameters, `Vth=512` and `Vrst=500`.
- **Single spike:** `leak_rate=0`, `charge_rate=0`, `refrac_sweeps=0`; one event `syn_i=600` to neuron 3 during sweep 0, before slot 3.
  - Expect `spike_valid` with `spike_idx=3` one cycle after slot 3 (Vn=599), then `V[3]=500`.
- **Leak:** neuron 5 is pre-charged to 510 with no input and `leak_rate=2`.
  - Expect V to decrease by 1 every 3rd sweep and never spike.
  - With `leak_rate=0`, expect V to reach 0 after 510 sweeps and stay at 0.
- **Refractory:** `refrac_sweeps=3`; neuron 7 spikes; keep injecting 600 to neuron 7 every sweep.
  - Expect the next spike exactly 4 sweeps later.
  - Expect events during refractory to be dropped.
- **Collision and saturation:**
  - `syn_valid` to neuron 2 in its own slot cycle with `charge_tick` high: expect `acc[2]=syn_i` after the cycle.
  - Eight events of 1023 to one neuron: expect `acc` to saturate at 4095.
- **Reset mid-sweep:** assert `reset` at `idx=9` with pending `acc` values.
  - Expect all outputs 0 and no spike until new input arrives.
  - Expect `idx=0` on the first cycle after release.
- **Config shadowing:** change `Vth` 512→700 at `idx=8`.
  - Expect neurons 8–15 in the current sweep to still use 512.
